wavelet_pair_feeder: RTL

- Frame-buffer reader that streams even/odd sample pairs into the lifting-based wavelet core. It supports a row pass and a column pass, so one block drives both dimensions of the 2D transform.
- It sits between the frame memory (two synchronous read ports) and the wavelet core's data_in_even/data_in_odd inputs.
- Adds start/busy/done control, ready/valid backpressure, line/frame markers, a programmable inter-line gap and abort, none of which the fixed free-running feeder provides.

---
 rtl/wavelet_pair_feeder.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/wavelet_pair_feeder.sv
// Streams even/odd sample pairs from a dual-port frame memory into the lifting wavelet core.
// Row or column pass, 2-entry credit-gated output FIFO, line gap, abort and done handshake.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | waiting for start; no reads, busy low
// S_RUN   | issuing pair reads whenever FIFO credit allows
// S_GAP   | counted idle cycles between lines, no reads
// S_DRAIN | all reads issued; waiting for FIFO and read pipe to empty
module wavelet_pair_feeder #(
  parameter int IMG_W    = 64,
  parameter int IMG_H    = 64,
  parameter int PIX_W    = 8,
  parameter int OUT_W    = 16,
  parameter int ADDR_W   = 16,
  parameter int LINE_GAP = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              col_mode,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr_even,
  output logic [ADDR_W-1:0] rd_addr_odd,
  input  logic [PIX_W-1:0]  rd_data_even,
  input  logic [PIX_W-1:0]  rd_data_odd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_even,
  output logic [OUT_W-1:0]  out_odd,
  output logic              out_sol,
  output logic              out_eol,
  output logic              out_eof
);

  localparam int MAXD = (IMG_W > IMG_H) ? IMG_W : IMG_H;
  localparam int CW   = $clog2(MAXD + 1);
  localparam int GW   = $clog2(LINE_GAP + 2);
  localparam int EW   = 2 * PIX_W + 3;

  localparam logic [CW-1:0] ROW_PAIRS_M1 = CW'(IMG_W / 2 - 1);
  localparam logic [CW-1:0] COL_PAIRS_M1 = CW'(IMG_H / 2 - 1);
  localparam logic [CW-1:0] ROW_LINES_M1 = CW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_LINES_M1 = CW'(IMG_W - 1);
  localparam logic [GW-1:0] GAP_M1       = GW'((LINE_GAP > 0) ? LINE_GAP - 1 : 0);

  localparam logic [ADDR_W-1:0] A_1  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] A_2  = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] A_W  = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0] A_2W = ADDR_W'(2 * IMG_W);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_GAP, S_DRAIN} state_t;

  state_t state, state_nxt;

  logic              col_q;
  logic [CW-1:0]     pair_left;
  logic [CW-1:0]     line_left;
  logic [GW-1:0]     gap_left;
  logic [ADDR_W-1:0] base, addr_e, addr_o;
  logic [ADDR_W-1:0] base_nxt;

  logic              inflight;
  logic [2:0]        tag_q;

  logic [EW-1:0]     fifo_mem [2];
  logic              wr_ptr, rd_ptr;
  logic [1:0]        count;
  logic [1:0]        occ_eff;
  logic [EW-1:0]     head;

  logic start_acc, issue, push, pop, rd_ok;
  logic line_end, frame_end, sol_now, drained;

  assign line_end  = (pair_left == '0);
  assign frame_end = line_end && (line_left == '0);
  assign sol_now   = (pair_left == (col_q ? COL_PAIRS_M1 : ROW_PAIRS_M1));

  // Credit counts the slot freed by a same-cycle pop so out_ready=1 sustains one pair per clock.
  assign pop     = out_valid && out_ready;
  assign occ_eff = count - {1'b0, pop} + {1'b0, inflight};
  assign rd_ok   = (occ_eff < 2'd2);

  assign start_acc = (state == S_IDLE) && start && !abort;
  assign issue     = (state == S_RUN) && rd_ok && !abort;
  assign push      = inflight && !abort;
  assign drained   = (count == 2'd0) && !inflight;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (start) state_nxt = S_RUN;
        S_RUN: begin
          if (issue && frame_end)                    state_nxt = S_DRAIN;
          else if (issue && line_end && LINE_GAP > 0) state_nxt = S_GAP;
        end
        S_GAP:   if (gap_left == '0) state_nxt = S_RUN;
        S_DRAIN: if (drained) state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  assign base_nxt = base + (col_q ? A_1 : A_W);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q     <= 1'b0;
      pair_left <= '0;
      line_left <= '0;
      base      <= '0;
      addr_e    <= '0;
      addr_o    <= '0;
    end else if (start_acc) begin
      col_q     <= col_mode;
      pair_left <= col_mode ? COL_PAIRS_M1 : ROW_PAIRS_M1;
      line_left <= col_mode ? COL_LINES_M1 : ROW_LINES_M1;
      base      <= '0;
      addr_e    <= '0;
      addr_o    <= col_mode ? A_W : A_1;
    end else if (issue) begin
      if (line_end) begin
        pair_left <= col_q ? COL_PAIRS_M1 : ROW_PAIRS_M1;
        line_left <= line_left - 1'b1;
        base      <= base_nxt;
        addr_e    <= base_nxt;
        addr_o    <= base_nxt + (col_q ? A_W : A_1);
      end else begin
        pair_left <= pair_left - 1'b1;
        addr_e    <= addr_e + (col_q ? A_2W : A_2);
        addr_o    <= addr_o + (col_q ? A_2W : A_2);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gap_left <= '0;
    end else if (issue && line_end && !frame_end) begin
      gap_left <= GAP_M1;
    end else if (state == S_GAP && gap_left != '0) begin
      gap_left <= gap_left - 1'b1;
    end
  end

  // Tags travel alongside the read so they land in the FIFO with their data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight <= 1'b0;
      tag_q    <= '0;
    end else begin
      inflight <= issue;
      if (issue) tag_q <= {frame_end, line_end, sol_now};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count       <= '0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
    end else if (abort && state != S_IDLE) begin
      count  <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= {tag_q, rd_data_odd, rd_data_even};
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  assign head      = fifo_mem[rd_ptr];
  assign out_valid = (count != 2'd0);
  assign out_even  = {{(OUT_W - PIX_W){1'b0}}, head[PIX_W-1:0]};
  assign out_odd   = {{(OUT_W - PIX_W){1'b0}}, head[2*PIX_W-1:PIX_W]};
  assign out_sol   = out_valid && head[EW-3];
  assign out_eol   = out_valid && head[EW-2];
  assign out_eof   = out_valid && head[EW-1];

  assign busy         = (state != S_IDLE);
  assign done         = (state == S_DRAIN) && drained && !abort;
  assign rd_en        = issue;
  assign rd_addr_even = addr_e;
  assign rd_addr_odd  = addr_o;

endmodule
